// File: rtl/ghost_pkg.sv
// ghost_pkg: shared constants and types for the ghost renderer.
//   - grid geometry of the blocked frame buffer (32 x 24 cells, 768 total)
//   - the 4x4 ghost sprite bitmap and a lookup helper
//   - renderer FSM states and the 2-bit pixel class
package ghost_pkg;

    localparam int GRID_W     = 32;
    localparam int GRID_H     = 24;
    localparam int BUF_SIZE   = 768;
    localparam int SPRITE_DIM = 4;

    // Sprite rows dy0..dy3 from MSB to LSB; within a row the leftmost bit is dx=0.
    localparam logic [15:0] SPRITE_BITMAP = 16'b0110_1111_1111_1010;

    typedef enum logic [1:0] {
        PX_BG   = 2'd0,
        PX_BODY = 2'd1,
        PX_EYE  = 2'd2
    } px_class_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Returns the bitmap bit for an in-sprite offset (dx, dy).
    function automatic logic sprite_bit(input logic [1:0] dx, input logic [1:0] dy);
        logic [3:0] idx;
        idx = {dy, dx};
        return SPRITE_BITMAP[4'd15 - idx];
    endfunction

endpackage

// File: rtl/ghost_sprite_lut.sv
// ghost_sprite_lut: combinational pixel classifier for the ghost sprite.
// Ports:
//   dx_i       in  6  signed column offset (col - ghost_x)
//   dy_i       in  6  signed row offset    (row - ghost_y)
//   px_class_o out 2  PX_BG outside the sprite or on a clear bitmap bit,
//                     PX_EYE at (1,1)/(2,1), PX_BODY elsewhere inside
module ghost_sprite_lut
    import ghost_pkg::*;
(
    input  logic signed [5:0] dx_i,
    input  logic signed [5:0] dy_i,
    output px_class_e         px_class_o
);

    logic dx_in_s;
    logic dy_in_s;
    logic bit_s;
    logic eye_s;

    // A negative offset has the sign bit set, so only non-negative offsets below
    // the sprite size are inside. Clipping falls out of this: cells past the
    // grid edge are never visited, and no offset ever wraps.
    assign dx_in_s = !dx_i[5] && (dx_i[4:0] < 5'(SPRITE_DIM));
    assign dy_in_s = !dy_i[5] && (dy_i[4:0] < 5'(SPRITE_DIM));
    assign bit_s   = sprite_bit(dx_i[1:0], dy_i[1:0]);
    assign eye_s   = (dy_i[1:0] == 2'd1) && ((dx_i[1:0] == 2'd1) || (dx_i[1:0] == 2'd2));

    // Classify the pixel from range check, bitmap bit and eye position.
    always_comb begin
        px_class_o = PX_BG;
        if (dx_in_s && dy_in_s && bit_s) begin
            if (eye_s) begin
                px_class_o = PX_EYE;
            end else begin
                px_class_o = PX_BODY;
            end
        end else begin
            px_class_o = PX_BG;
        end
    end

endmodule

// File: rtl/ghost_renderer.sv
// ghost_renderer: frame-buffer producer that sweeps all 768 blocked cells once
// per frame, writing background or a 4x4 ghost sprite latched at frame start.
// Ports:
//   clk           in  1   system clock
//   rst           in  1   synchronous active-high reset
//   hc, vc        in  10  VGA counters; frame start = rising edge of hc==0&&vc==0
//   ghost_x       in  5   sprite left column
//   ghost_y       in  5   sprite top row (>=24 is off-screen)
//   write_address out 10  buffer address {row, col}
//   write_data    out 8   colour for write_address
//   frame_done    out 1   one-cycle pulse alongside address 767
//   overrun       out 1   sticky: frame start arrived while drawing
module ghost_renderer
    import ghost_pkg::*;
#(
    parameter logic [7:0] BG_COLOR    = 8'h00,
    parameter logic [7:0] GHOST_COLOR = 8'hE0,
    parameter logic [7:0] EYE_COLOR   = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] hc,
    input  logic [9:0] vc,
    input  logic [4:0] ghost_x,
    input  logic [4:0] ghost_y,
    output logic [9:0] write_address,
    output logic [7:0] write_data,
    output logic       frame_done,
    output logic       overrun
);

    state_e      state_q, state_d;
    logic [4:0]  col_q, col_d;
    logic [4:0]  row_q, row_d;
    logic [4:0]  gx_q, gx_d;
    logic [4:0]  gy_q, gy_d;
    logic [9:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;
    logic        ovr_q, ovr_d;
    logic        fs_prev_q;

    logic              fs_cond_s;
    logic              fs_s;
    logic              last_cell_s;
    logic signed [5:0] dx_s;
    logic signed [5:0] dy_s;
    px_class_e         px_s;
    logic [7:0]        colour_s;

    assign fs_cond_s   = (hc == 10'd0) && (vc == 10'd0);
    assign fs_s        = fs_cond_s && !fs_prev_q;
    assign last_cell_s = ({row_q, col_q} == 10'(BUF_SIZE - 1));

    // Zero-extended difference taken in 6 bits so offsets left of / above the
    // sprite come out negative instead of wrapping to a small positive value.
    assign dx_s = {1'b0, col_q} - {1'b0, gx_q};
    assign dy_s = {1'b0, row_q} - {1'b0, gy_q};

    ghost_sprite_lut u_lut (
        .dx_i       (dx_s),
        .dy_i       (dy_s),
        .px_class_o (px_s)
    );

    // Map the pixel class onto the colour parameters.
    always_comb begin
        colour_s = BG_COLOR;
        case (px_s)
            PX_BODY: colour_s = GHOST_COLOR;
            PX_EYE:  colour_s = EYE_COLOR;
            PX_BG:   colour_s = BG_COLOR;
            default: colour_s = BG_COLOR;
        endcase
    end

    // Next-state and registered-output logic for the sweep FSM.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        gx_d    = gx_q;
        gy_d    = gy_q;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ovr_d   = ovr_q;
        case (state_q)
            ST_DRAW: begin
                // The cell for the current counters is written even on a
                // restart, so the buffer always sees a consistent pair.
                addr_d = {row_q, col_q};
                data_d = colour_s;
                if (fs_s) begin
                    ovr_d = 1'b1;
                    gx_d  = ghost_x;
                    gy_d  = ghost_y;
                    col_d = 5'd0;
                    row_d = 5'd0;
                end else if (last_cell_s) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (col_q == 5'(GRID_W - 1)) begin
                    col_d = 5'd0;
                    row_d = row_q + 5'd1;
                end else begin
                    col_d = col_q + 5'd1;
                end
            end
            ST_IDLE, ST_DONE: begin
                // Outputs keep the last pair; the buffer rewrites it harmlessly.
                if (fs_s) begin
                    gx_d    = ghost_x;
                    gy_d    = ghost_y;
                    col_d   = 5'd0;
                    row_d   = 5'd0;
                    state_d = ST_DRAW;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter, latch and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            col_q     <= 5'd0;
            row_q     <= 5'd0;
            gx_q      <= 5'd0;
            gy_q      <= 5'd0;
            addr_q    <= 10'd0;
            data_q    <= BG_COLOR;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            fs_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            gx_q      <= gx_d;
            gy_q      <= gy_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
            fs_prev_q <= fs_cond_s;
        end
    end

    assign write_address = addr_q;
    assign write_data    = data_q;
    assign frame_done    = done_q;
    assign overrun       = ovr_q;

endmodule

// File: tb/tb_ghost_renderer.sv
// tb_ghost_renderer: directed self-checking bench for ghost_renderer.
module tb_ghost_renderer;

    logic       clk;
    logic       rst;
    logic [9:0] hc;
    logic [9:0] vc;
    logic [4:0] ghost_x;
    logic [4:0] ghost_y;
    logic [9:0] write_address;
    logic [7:0] write_data;
    logic       frame_done;
    logic       overrun;

    int errors = 0;
    int checks = 0;
    logic [7:0] mem [0:767];

    ghost_renderer dut (
        .clk           (clk),
        .rst           (rst),
        .hc            (hc),
        .vc            (vc),
        .ghost_x       (ghost_x),
        .ghost_y       (ghost_y),
        .write_address (write_address),
        .write_data    (write_data),
        .frame_done    (frame_done),
        .overrun       (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int count_nonbg(input int lo, input int hi, input int stride);
        int n;
        n = 0;
        for (int a = lo; a <= hi; a += stride) begin
            if (mem[a] !== 8'h00) n++;
        end
        return n;
    endfunction

    // Raise the frame-start condition for 'hold' clocks and record the sweep.
    // abort_at >= 0 stops after that address; chg_at >= 0 changes ghost_x there.
    task automatic sweep(input string tag, input int hold, input int abort_at,
                         input int chg_at, input logic [4:0] chg_x, input logic exp_ovr);
        int addr_bad;
        int done_bad;
        addr_bad = 0;
        done_bad = 0;
        for (int a = 0; a < 768; a++) mem[a] = 8'hxx;
        hc = 10'd0;
        vc = 10'd0;
        step();
        for (int k = 0; k < 768; k++) begin
            if (k + 1 >= hold) hc = 10'd5;
            if (k == chg_at) ghost_x = chg_x;
            step();
            if (write_address !== 10'(k)) addr_bad++;
            if (frame_done !== (k == 767)) done_bad++;
            mem[k] = write_data;
            if (k == abort_at) break;
        end
        check({tag, "_addr_seq"}, addr_bad, 0);
        check({tag, "_done_seq"}, done_bad, 0);
        if (abort_at < 0) begin
            step();
            check({tag, "_hold_addr"}, {22'd0, write_address}, 32'd767);
            check({tag, "_hold_done"}, {31'd0, frame_done}, 32'd0);
        end
        check({tag, "_overrun"}, {31'd0, overrun}, {31'd0, exp_ovr});
    endtask

    initial begin
        rst     = 1'b1;
        hc      = 10'd5;
        vc      = 10'd5;
        ghost_x = 5'd5;
        ghost_y = 5'd2;
        repeat (3) step();
        check("rst_addr", {22'd0, write_address}, 32'd0);
        check("rst_data", {24'd0, write_data}, 32'h00);
        check("rst_done", {31'd0, frame_done}, 32'd0);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        rst = 1'b0;
        repeat (3) step();
        check("idle_addr", {22'd0, write_address}, 32'd0);

        // Condition held 3 clocks -> one sweep; ghost_x changes to 10 mid-sweep.
        sweep("s1", 3, -1, 50, 5'd10, 1'b0);
        check("s1_c69", {24'd0, mem[69]}, 32'h00);
        check("s1_c70", {24'd0, mem[70]}, 32'hE0);
        check("s1_c102", {24'd0, mem[102]}, 32'hFF);
        check("s1_c103", {24'd0, mem[103]}, 32'hFF);
        check("s1_c165", {24'd0, mem[165]}, 32'hE0);
        check("s1_c166", {24'd0, mem[166]}, 32'h00);
        check("s1_c106", {24'd0, mem[106]}, 32'h00);
        check("s1_count", count_nonbg(0, 767, 1), 32'd12);

        // Next frame picks up ghost_x=10.
        sweep("s2", 1, -1, -1, 5'd0, 1'b0);
        check("s2_c70", {24'd0, mem[70]}, 32'h00);
        check("s2_c75", {24'd0, mem[75]}, 32'hE0);
        check("s2_c107", {24'd0, mem[107]}, 32'hFF);
        check("s2_count", count_nonbg(0, 767, 1), 32'd12);

        // Clipping at the bottom-right corner.
        ghost_x = 5'd30;
        ghost_y = 5'd22;
        sweep("s3", 1, -1, -1, 5'd30, 1'b0);
        check("s3_c734", {24'd0, mem[734]}, 32'h00);
        check("s3_c735", {24'd0, mem[735]}, 32'hE0);
        check("s3_c766", {24'd0, mem[766]}, 32'hE0);
        check("s3_c767", {24'd0, mem[767]}, 32'hFF);
        check("s3_count", count_nonbg(0, 767, 1), 32'd3);
        check("s3_row0", count_nonbg(0, 31, 1), 32'd0);
        check("s3_col0", count_nonbg(0, 767, 32), 32'd0);
        check("s3_dhold", {24'd0, write_data}, 32'hFF);

        // Off-screen row: no sprite at all.
        ghost_x = 5'd4;
        ghost_y = 5'd24;
        sweep("s4", 1, -1, -1, 5'd4, 1'b0);
        check("s4_count", count_nonbg(0, 767, 1), 32'd0);

        // Frame start during DRAW at cell 100 -> overrun, restart, full sweep.
        ghost_y = 5'd0;
        sweep("o1", 1, 100, -1, 5'd4, 1'b0);
        sweep("o2", 1, -1, -1, 5'd4, 1'b1);
        check("o2_count", count_nonbg(0, 767, 1), 32'd12);

        // Reset in the middle of a sweep.
        sweep("r1", 1, 299, -1, 5'd4, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("r_addr", {22'd0, write_address}, 32'd0);
        check("r_data", {24'd0, write_data}, 32'h00);
        check("r_ovr", {31'd0, overrun}, 32'd0);
        check("r_done", {31'd0, frame_done}, 32'd0);
        begin
            int moved;
            moved = 0;
            for (int i = 0; i < 40; i++) begin
                step();
                if (write_address !== 10'd0 || write_data !== 8'h00 || frame_done !== 1'b0) moved++;
            end
            check("r_idle_hold", moved, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
